// File: rtl/spi_slave_frame_if.sv
// spi_slave_frame_if -- SPI frame slave bus bundle.
//   cs_n     : chip select from master, active-low
//   mosi     : serial data from master
//   miso     : serial data to master
//   tx_word  : next word to transmit (driven by the local side)
//   rx_word  : last complete received word
//   rx_valid : one-cycle pulse, rx_word updated
//   tx_req   : one-cycle pulse, next tx_word required
//   word_idx : words completed in the current frame
//   overrun  : sticky, frame exceeded MAX_WORDS
// Modport slave is the SPI slave block; modport master is the opposite side.
interface spi_slave_frame_if #(
    parameter int WORD_W    = 8,
    parameter int MAX_WORDS = 4
) ();
    localparam int IDX_W = $clog2(MAX_WORDS + 1);

    logic              cs_n;
    logic              mosi;
    logic              miso;
    logic [WORD_W-1:0] tx_word;
    logic [WORD_W-1:0] rx_word;
    logic              rx_valid;
    logic              tx_req;
    logic [IDX_W-1:0]  word_idx;
    logic              overrun;

    modport slave (
        input  cs_n, mosi, tx_word,
        output miso, rx_word, rx_valid, tx_req, word_idx, overrun
    );

    modport master (
        output cs_n, mosi, tx_word,
        input  miso, rx_word, rx_valid, tx_req, word_idx, overrun
    );
endinterface

// File: rtl/spi_slave_frame.sv
// spi_slave_frame -- SPI mode-0 slave that receives/transmits frames of up
// to MAX_WORDS words of WORD_W bits each.
//   sclk  : SPI clock, all state advances on its rising edge
//   rst_n : asynchronous active-low reset
//   bus   : spi_slave_frame_if.slave (cs_n, mosi, miso, tx_word, rx_word,
//           rx_valid, tx_req, word_idx, overrun)
// Parameters: WORD_W (4..32), MAX_WORDS (1..16), LSB_FIRST (0 = MSB first).
module spi_slave_frame #(
    parameter int WORD_W    = 8,
    parameter int MAX_WORDS = 4,
    parameter int LSB_FIRST = 0
) (
    input  logic             sclk,
    input  logic             rst_n,
    spi_slave_frame_if.slave bus
);
    localparam int BIT_W = $clog2(WORD_W);
    localparam int IDX_W = $clog2(MAX_WORDS + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(MAX_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_OVERFLOW
    } state_t;

    state_t            state, state_nx;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_nx;
    logic [IDX_W-1:0]  word_idx, word_idx_nx;
    logic              word_done;
    logic              sampling;
    logic [WORD_W-1:0] rx_sr, rx_sr_nx;
    logic [WORD_W-1:0] rx_word_q;
    logic [WORD_W-1:0] tx_hold;
    logic              rx_valid_q, tx_req_q, overrun_q;
    logic              miso_d;
    logic              frame_rst_n;

    // Frame-scoped state is cleared by either reset or cs_n going high;
    // rx_word, tx_hold and overrun survive cs_n and only see rst_n.
    assign frame_rst_n = rst_n & ~bus.cs_n;

    // IDLE also samples: its first edge carries bit 0 of word 0.
    assign sampling = (state != S_OVERFLOW);

    generate
        if (LSB_FIRST != 0) begin : g_rx_lsb
            assign rx_sr_nx = {bus.mosi, rx_sr[WORD_W-1:1]};
        end else begin : g_rx_msb
            assign rx_sr_nx = {rx_sr[WORD_W-2:0], bus.mosi};
        end
    endgenerate

    // Next-state / bit and word counting
    always_comb begin
        state_nx    = state;
        bit_cnt_nx  = bit_cnt;
        word_idx_nx = word_idx;
        word_done   = 1'b0;
        unique case (state)
            S_IDLE, S_ACTIVE: begin
                state_nx = S_ACTIVE;
                if (bit_cnt == BIT_LAST) begin
                    bit_cnt_nx  = '0;
                    word_done   = 1'b1;
                    word_idx_nx = word_idx + IDX_W'(1);
                    if (word_idx_nx == IDX_MAX) begin
                        state_nx = S_OVERFLOW;
                    end
                end else begin
                    bit_cnt_nx = bit_cnt + BIT_W'(1);
                end
            end
            S_OVERFLOW: begin
                state_nx = S_OVERFLOW;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Frame state register
    always_ff @(posedge sclk or negedge frame_rst_n) begin
        if (!frame_rst_n) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            word_idx   <= '0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
        end else begin
            state      <= state_nx;
            bit_cnt    <= bit_cnt_nx;
            word_idx   <= word_idx_nx;
            rx_valid_q <= word_done;
            tx_req_q   <= word_done;
        end
    end

    // Data registers; the cs_n guard keeps them idle while deselected since
    // the frame state is then held in IDLE by frame_rst_n.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sr     <= '0;
            rx_word_q <= '0;
            tx_hold   <= '0;
            overrun_q <= 1'b0;
        end else if (!bus.cs_n) begin
            if (sampling) begin
                rx_sr <= rx_sr_nx;
                if (bit_cnt == '0) begin
                    tx_hold <= bus.tx_word;
                end
            end
            if (word_done) begin
                rx_word_q <= rx_sr_nx;
            end
            if (state == S_IDLE) begin
                overrun_q <= 1'b0;
            end else if (state == S_OVERFLOW) begin
                overrun_q <= 1'b1;
            end
        end
    end

    // Bit 0 of each word comes straight from tx_word so the local side can
    // answer tx_req within the same cycle; later bits come from tx_hold.
    always_comb begin
        miso_d = 1'b0;
        if (rst_n && !bus.cs_n && sampling) begin
            if (bit_cnt == '0) begin
                miso_d = (LSB_FIRST != 0) ? bus.tx_word[0] : bus.tx_word[WORD_W-1];
            end else begin
                miso_d = (LSB_FIRST != 0) ? tx_hold[bit_cnt] : tx_hold[BIT_LAST - bit_cnt];
            end
        end
    end

    assign bus.miso     = miso_d;
    assign bus.rx_word  = rx_word_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.tx_req   = tx_req_q;
    assign bus.word_idx = word_idx;
    assign bus.overrun  = overrun_q;
endmodule

// File: tb/tb_spi_slave_frame.sv
// tb_spi_slave_frame -- self-checking bench for spi_slave_frame.
// Three instances: default (8-bit MSB first), LSB_FIRST=1, WORD_W=12.
// The reference model describes a frame as a list of words and derives the
// expected serial bits, pulses and counters from word/bit positions.
`timescale 1ns/1ps
module tb_spi_slave_frame;
    localparam int MAXW = 4;
    localparam int NDUT = 3;

    int unsigned n_chk = 0;
    int unsigned n_fail = 0;

    logic sclk = 1'b0;
    logic rst_n = 1'b0;
    always #5 sclk = ~sclk;

    spi_slave_frame_if #(.WORD_W(8),  .MAX_WORDS(MAXW)) if_d ();
    spi_slave_frame_if #(.WORD_W(8),  .MAX_WORDS(MAXW)) if_l ();
    spi_slave_frame_if #(.WORD_W(12), .MAX_WORDS(MAXW)) if_w ();

    spi_slave_frame #(.WORD_W(8),  .MAX_WORDS(MAXW), .LSB_FIRST(0)) u_d (.sclk(sclk), .rst_n(rst_n), .bus(if_d.slave));
    spi_slave_frame #(.WORD_W(8),  .MAX_WORDS(MAXW), .LSB_FIRST(1)) u_l (.sclk(sclk), .rst_n(rst_n), .bus(if_l.slave));
    spi_slave_frame #(.WORD_W(12), .MAX_WORDS(MAXW), .LSB_FIRST(0)) u_w (.sclk(sclk), .rst_n(rst_n), .bus(if_w.slave));

    int cfg_w   [NDUT] = '{8, 8, 12};
    int cfg_lsb [NDUT] = '{0, 1, 0};

    logic        cs_v   [NDUT];
    logic        mosi_v [NDUT];
    logic [31:0] tx_v   [NDUT];

    assign if_d.cs_n = cs_v[0];  assign if_d.mosi = mosi_v[0];  assign if_d.tx_word = tx_v[0][7:0];
    assign if_l.cs_n = cs_v[1];  assign if_l.mosi = mosi_v[1];  assign if_l.tx_word = tx_v[1][7:0];
    assign if_w.cs_n = cs_v[2];  assign if_w.mosi = mosi_v[2];  assign if_w.tx_word = tx_v[2][11:0];

    logic [31:0] o_rx [NDUT];
    logic [31:0] o_idx [NDUT];
    logic        o_val [NDUT];
    logic        o_req [NDUT];
    logic        o_ovr [NDUT];
    logic        o_miso [NDUT];

    assign o_rx[0] = 32'(if_d.rx_word);  assign o_idx[0] = 32'(if_d.word_idx);
    assign o_rx[1] = 32'(if_l.rx_word);  assign o_idx[1] = 32'(if_l.word_idx);
    assign o_rx[2] = 32'(if_w.rx_word);  assign o_idx[2] = 32'(if_w.word_idx);
    assign o_val[0] = if_d.rx_valid;  assign o_req[0] = if_d.tx_req;  assign o_ovr[0] = if_d.overrun;  assign o_miso[0] = if_d.miso;
    assign o_val[1] = if_l.rx_valid;  assign o_req[1] = if_l.tx_req;  assign o_ovr[1] = if_l.overrun;  assign o_miso[1] = if_l.miso;
    assign o_val[2] = if_w.rx_valid;  assign o_req[2] = if_w.tx_req;  assign o_ovr[2] = if_w.overrun;  assign o_miso[2] = if_w.miso;

    // Reference state kept per instance
    logic [31:0] exp_rx  [NDUT];
    logic        exp_ovr [NDUT];

    // Frame description consumed by run_frame
    logic [31:0] f_mosi [8];
    logic [31:0] f_tx   [8];

    function automatic logic pick(input logic [31:0] v, input int d, input int j);
        int k;
        k = (cfg_lsb[d] != 0) ? j : cfg_w[d] - 1 - j;
        return v[k];
    endfunction

    function automatic logic [31:0] wmask(input int d);
        return (32'h1 << cfg_w[d]) - 32'h1;
    endfunction

    // Plays one frame of nw words (last word cut to part bits if part > 0)
    // and compares every bit period against the word-level model.
    task automatic run_frame(input int d, input int nw, input int part, input bit keep_cs, input string tag);
        int    nb;
        int    exp_idx;
        logic  exp_miso;
        logic  done;
        tx_v[d] = f_tx[0];
        cs_v[d] = 1'b0;
        for (int wi = 0; wi < nw; wi++) begin
            nb = (wi == nw - 1 && part > 0) ? part : cfg_w[d];
            for (int j = 0; j < nb; j++) begin
                mosi_v[d] = pick(f_mosi[wi], d, j);
                if (j > 0) tx_v[d] = $urandom;
                #1;
                exp_miso = (wi < MAXW) ? pick(f_tx[wi], d, j) : 1'b0;
                n_chk++;
                if (o_miso[d] !== exp_miso) begin n_fail++; $display("FAIL %s miso d%0d w%0d b%0d: got %b exp %b", tag, d, wi, j, o_miso[d], exp_miso); end
                @(posedge sclk);
                @(negedge sclk);
                done = (wi < MAXW) && (j == cfg_w[d] - 1);
                if (done) exp_rx[d] = f_mosi[wi] & wmask(d);
                exp_idx = (wi >= MAXW) ? MAXW : wi + (done ? 1 : 0);
                n_chk++;
                if (o_val[d] !== done) begin n_fail++; $display("FAIL %s rx_valid d%0d w%0d b%0d: got %b exp %b", tag, d, wi, j, o_val[d], done); end
                n_chk++;
                if (o_req[d] !== done) begin n_fail++; $display("FAIL %s tx_req d%0d w%0d b%0d: got %b exp %b", tag, d, wi, j, o_req[d], done); end
                n_chk++;
                if (o_rx[d] !== exp_rx[d]) begin n_fail++; $display("FAIL %s rx_word d%0d w%0d b%0d: got %h exp %h", tag, d, wi, j, o_rx[d], exp_rx[d]); end
                n_chk++;
                if (o_idx[d] !== 32'(exp_idx)) begin n_fail++; $display("FAIL %s word_idx d%0d w%0d b%0d: got %0d exp %0d", tag, d, wi, j, o_idx[d], exp_idx); end
                n_chk++;
                if (o_ovr[d] !== (wi >= MAXW)) begin n_fail++; $display("FAIL %s overrun d%0d w%0d b%0d: got %b exp %b", tag, d, wi, j, o_ovr[d], (wi >= MAXW)); end
                if (done) tx_v[d] = f_tx[wi + 1];
            end
        end
        exp_ovr[d] = (nw > MAXW);
        if (!keep_cs) begin
            cs_v[d] = 1'b1;
            #1;
            n_chk++;
            if (o_idx[d] !== 32'd0) begin n_fail++; $display("FAIL %s cs_idx d%0d: got %0d exp 0", tag, d, o_idx[d]); end
            n_chk++;
            if (o_val[d] !== 1'b0 || o_req[d] !== 1'b0) begin n_fail++; $display("FAIL %s cs_pulses d%0d: got %b%b exp 00", tag, d, o_val[d], o_req[d]); end
            n_chk++;
            if (o_miso[d] !== 1'b0) begin n_fail++; $display("FAIL %s cs_miso d%0d: got %b exp 0", tag, d, o_miso[d]); end
            n_chk++;
            if (o_rx[d] !== exp_rx[d]) begin n_fail++; $display("FAIL %s cs_rx d%0d: got %h exp %h", tag, d, o_rx[d], exp_rx[d]); end
            n_chk++;
            if (o_ovr[d] !== exp_ovr[d]) begin n_fail++; $display("FAIL %s cs_ovr d%0d: got %b exp %b", tag, d, o_ovr[d], exp_ovr[d]); end
            @(negedge sclk);
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < NDUT; d++) begin
            cs_v[d] = 1'b1; mosi_v[d] = 1'b1; tx_v[d] = '1;
            exp_rx[d] = '0; exp_ovr[d] = 1'b0;
        end
        cs_v[0] = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge sclk);
        for (int d = 0; d < NDUT; d++) begin
            n_chk++;
            if (o_rx[d] !== 32'd0 || o_idx[d] !== 32'd0) begin n_fail++; $display("FAIL reset_regs d%0d: got rx %h idx %0d exp 0 0", d, o_rx[d], o_idx[d]); end
            n_chk++;
            if ({o_val[d], o_req[d], o_ovr[d], o_miso[d]} !== 4'b0000) begin n_fail++; $display("FAIL reset_bits d%0d: got %b%b%b%b exp 0000", d, o_val[d], o_req[d], o_ovr[d], o_miso[d]); end
        end
        cs_v[0] = 1'b1;
        rst_n = 1'b1;
        @(negedge sclk);
    endtask

    task automatic test_basic();
        f_mosi[0] = 32'hA5; f_tx[0] = 32'h3C; f_tx[1] = $urandom;
        run_frame(0, 1, 0, 1'b0, "basic");
        n_chk++;
        if (o_rx[0] !== 32'hA5) begin n_fail++; $display("FAIL basic_rx: got %h exp a5", o_rx[0]); end
    endtask

    task automatic test_lsb_first();
        f_mosi[0] = 32'h01; f_tx[0] = 32'h80;
        for (int i = 1; i < 8; i++) begin f_mosi[i] = $urandom; f_tx[i] = $urandom; end
        run_frame(1, 3, 0, 1'b0, "lsb");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) begin f_mosi[i] = 32'h11 * (i + 1); f_tx[i] = $urandom; end
        run_frame(0, 5, 0, 1'b0, "overflow");
        n_chk++;
        if (o_rx[0] !== 32'h44) begin n_fail++; $display("FAIL overflow_hold: got %h exp 44", o_rx[0]); end
    endtask

    task automatic test_abort();
        for (int i = 0; i < 8; i++) begin f_mosi[i] = $urandom; f_tx[i] = $urandom; end
        run_frame(0, 2, 3, 1'b0, "abort");
        f_mosi[0] = 32'h7E;
        run_frame(0, 1, 0, 1'b0, "abort_new");
        n_chk++;
        if (o_rx[0] !== 32'h7E || o_ovr[0] !== 1'b0) begin n_fail++; $display("FAIL abort_final: got rx %h ovr %b exp 7e 0", o_rx[0], o_ovr[0]); end
    endtask

    task automatic test_w12();
        for (int i = 0; i < 8; i++) begin f_mosi[i] = $urandom; f_tx[i] = $urandom; end
        f_mosi[1] = 32'h5A5; f_tx[1] = 32'hABC;
        run_frame(2, 2, 0, 1'b0, "w12");
        n_chk++;
        if (o_rx[2] !== 32'h5A5) begin n_fail++; $display("FAIL w12_rx: got %h exp 5a5", o_rx[2]); end
    endtask

    task automatic test_reset_midword();
        for (int i = 0; i < 8; i++) begin f_mosi[i] = $urandom; f_tx[i] = $urandom; end
        run_frame(0, 3, 3, 1'b1, "pre_rst");
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (o_rx[0] !== 32'd0 || o_idx[0] !== 32'd0) begin n_fail++; $display("FAIL midrst_regs: got rx %h idx %0d exp 0 0", o_rx[0], o_idx[0]); end
        n_chk++;
        if ({o_val[0], o_req[0], o_ovr[0], o_miso[0]} !== 4'b0000) begin n_fail++; $display("FAIL midrst_bits: got %b%b%b%b exp 0000", o_val[0], o_req[0], o_ovr[0], o_miso[0]); end
        for (int d = 0; d < NDUT; d++) begin exp_rx[d] = '0; exp_ovr[d] = 1'b0; end
        @(negedge sclk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin f_mosi[i] = $urandom; f_tx[i] = $urandom; end
        run_frame(0, 1, 0, 1'b0, "post_rst");
    endtask

    task automatic test_random();
        int d, nw, part;
        for (int it = 0; it < 12; it++) begin
            d    = $urandom_range(0, NDUT - 1);
            nw   = $urandom_range(1, 6);
            part = $urandom_range(0, cfg_w[d] - 1);
            for (int i = 0; i < 8; i++) begin f_mosi[i] = $urandom; f_tx[i] = $urandom; end
            run_frame(d, nw, part, 1'b0, "random");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_lsb_first();
        test_overflow();
        test_abort();
        test_w12();
        test_reset_midword();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
